sram_port_arbiter: RTL

Shares one single-ported synchronous SRAM between the instruction-fetch requester and the load/store requester of the multi-cycle CPU core. Each requester uses a req/addr_ok/data_ok handshake. The block grants at most one transaction at a time, counts the fixed SRAM read latency, and returns each response only to its owner. Data accesses have priority, with an anti-starvation limit that guarantees fetch progress.

---
 rtl/sram_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - fetch/load-store arbiter for one single-ported synchronous SRAM
//
// Purpose:
//   Grants at most one SRAM transaction at a time to either the instruction
//   fetch requester or the load/store requester, counts the fixed SRAM read
//   latency and routes the response back to the owner only. Data accesses have
//   priority; after STARVE_LIMIT consecutive data grants with inst_req pending,
//   the next grant goes to inst.
//
// Parameters:
//   SRAM_LAT      SRAM read latency from the sram_en cycle (1..7)
//   STARVE_LIMIT  consecutive data grants allowed while inst waits (1..15)
//
// Optional build macro:
//   SRAM_ARB_PERF_EN  builds the perf_* grant/stall counters; without it the
//                     perf_* ports are tied to 0.
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   inst_req/addr                       fetch request in
//   inst_addr_ok/data_ok/rdata          fetch accept, response, data out
//   data_req/wr/wstrb/addr/wdata        load/store request in
//   data_addr_ok/data_ok/rdata          load/store accept, response, data out
//   sram_en/we/addr/wdata, sram_rdata   SRAM access interface
//   perf_inst_grants/data_grants/stall_cycles  performance counters

module sram_port_arbiter #(
  parameter int SRAM_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [31:0] perf_inst_grants,
  output logic [31:0] perf_data_grants,
  output logic [31:0] perf_stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

  localparam logic [2:0] LAT_INIT   = 3'(SRAM_LAT);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_t      state;
  owner_t      owner;
  logic        owner_store;
  logic [2:0]  cnt;
  logic [3:0]  streak;

  logic        resp_cycle;
  logic        grant_window;
  logic        inst_forced;
  logic        data_win;
  logic        inst_win;
  logic        data_store;

  // The response cycle doubles as a grant opportunity, giving back-to-back
  // accesses every SRAM_LAT cycles.
  assign resp_cycle   = (state == BUSY) && (cnt == 3'd1);
  // Gated by resetn so the combinational handshakes are quiet during reset.
  assign grant_window = resetn && ((state == IDLE) || resp_cycle);
  assign inst_forced  = inst_req && (streak == STREAK_MAX);
  assign data_win     = grant_window && data_req && !inst_forced;
  assign inst_win     = grant_window && inst_req && !data_win;
  assign data_store   = data_win && data_wr;

  assign inst_addr_ok = inst_win;
  assign data_addr_ok = data_win;

  assign sram_en    = data_win || inst_win;
  assign sram_we    = data_store ? data_wstrb : 4'b0000;
  assign sram_wdata = data_store ? data_wdata : 32'h0;
  assign sram_addr  = data_win ? data_addr : (inst_win ? inst_addr : 32'h0);

  assign inst_data_ok = resp_cycle && (owner == OWN_INST);
  assign data_data_ok = resp_cycle && (owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
  // Stores still pulse data_ok but never expose the SRAM read bus.
  assign data_rdata   = (data_data_ok && !owner_store) ? sram_rdata : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      owner_store <= 1'b0;
      cnt         <= 3'd0;
      streak      <= 4'd0;
    end else begin
      if (data_win || inst_win) begin
        state       <= BUSY;
        cnt         <= LAT_INIT;
        owner       <= data_win ? OWN_DATA : OWN_INST;
        owner_store <= data_store;
      end else if (state == BUSY) begin
        if (cnt == 3'd1) begin
          state       <= IDLE;
          owner       <= OWN_NONE;
          owner_store <= 1'b0;
          cnt         <= 3'd0;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end

      // Streak measures how long inst has waited behind data grants.
      if (!inst_req || inst_win) begin
        streak <= 4'd0;
      end else if (data_win && (streak != STREAK_MAX)) begin
        streak <= streak + 4'd1;
      end
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic stall;

  // A cycle stalls when any requester is asking and is not accepted.
  assign stall = (inst_req && !inst_win) || (data_req && !data_win);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_inst_grants  <= 32'h0;
      perf_data_grants  <= 32'h0;
      perf_stall_cycles <= 32'h0;
    end else begin
      if (inst_win) perf_inst_grants  <= perf_inst_grants + 32'd1;
      if (data_win) perf_data_grants  <= perf_data_grants + 32'd1;
      if (stall)    perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  assign perf_inst_grants  = 32'h0;
  assign perf_data_grants  = 32'h0;
  assign perf_stall_cycles = 32'h0;
`endif

endmodule
